spm_memory_unit: RTL

- Unified program/data memory for the 8-bit RISC SPM, with the address register, read/write datapath and a byte-serial boot loader.
- Consumes the control unit's addr_wr_en, mem_rd_en and mem_wr_en strobes.
- Supplies instruction bytes (to IR) and operand/branch-target bytes (to bus_2 via mux_2 select 2).
- Holds the CPU in hold while a program image is streamed in after reset.

---
 rtl/spm_memory_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/spm_memory_unit.sv
// Unified program/data memory for the 8-bit RISC SPM. It holds the address register,
// the read/write datapath and a byte-serial boot loader that keeps the CPU in hold until the image is in.
module spm_memory_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  boot_en,
  input  logic                  addr_wr_en,
  input  logic                  mem_rd_en,
  input  logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] bus_1_in,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  ld_valid,
  input  logic                  ld_last,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  load_err
);

  typedef enum logic [1:0] {BOOT_CHK, LOAD, FINISH, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] ld_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_run;
  logic                  ld_xfer;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign in_run  = (state == RUN);
  assign ld_xfer = (state == LOAD) && ld_valid && ld_ready;

  // Loader and CPU never write in the same state, so one shared write port suffices.
  assign mem_we    = !in_rst && (ld_xfer || (in_run && mem_wr_en));
  assign mem_waddr = ld_xfer ? ld_ptr  : addr_q;
  assign mem_wdata = ld_xfer ? ld_data : wr_data;

  always_ff @(posedge in_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Asynchronous read gives read-before-write behaviour on a simultaneous write.
  assign mem_dout = (in_run && mem_rd_en) ? mem[addr_q] : '0;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= BOOT_CHK;
      addr_q   <= '0;
      ld_ptr   <= '0;
      ld_count <= '0;
      load_err <= 1'b0;
      cpu_hold <= 1'b1;
      ld_ready <= 1'b0;
    end else begin
      case (state)
        BOOT_CHK: begin
          if (boot_en) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
          end else begin
            state    <= RUN;
            cpu_hold <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_xfer) begin
            ld_count <= ld_count + 1'b1;
            // The pointer saturates at the top word; an image that reaches it without ld_last is an overflow.
            if (ld_ptr != LAST_PTR) begin
              ld_ptr <= ld_ptr + 1'b1;
            end
            if (ld_last || (ld_ptr == LAST_PTR)) begin
              state    <= FINISH;
              ld_ready <= 1'b0;
              if (!ld_last) begin
                load_err <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          state    <= RUN;
          cpu_hold <= 1'b0;
        end
        RUN: begin
          if (addr_wr_en) begin
            addr_q <= bus_1_in[ADDR_WIDTH-1:0];
          end
        end
        default: begin
          state <= BOOT_CHK;
        end
      endcase
    end
  end

endmodule
